// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider (seq_div) and its iteration
// slice (div_step).
//   state_t    : FSM state encoding (S_IDLE, S_PREP, S_ITER, S_FIX)
//   cnt_width  : width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  // Enough bits to count 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division iteration.
// The remainder:quotient pair is shifted left by one bit, the divisor is
// trial-subtracted from the widened partial remainder, and the subtraction is
// discarded (restored) when it borrows. The new quotient bit enters at the LSB.
// Ports:
//   rem_in   in   WIDTH  partial remainder
//   quo_in   in   WIDTH  dividend bits still to be consumed / quotient so far
//   divisor  in   WIDTH  divisor magnitude
//   rem_out  out  WIDTH  updated partial remainder
//   quo_out  out  WIDTH  updated quotient/dividend shift register
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the top bit of the difference is a clean borrow.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    borrow  = trial[WIDTH];
    rem_out = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with start/busy/done
// handshake. Signed division works on magnitudes and fixes the signs at the
// end: quotient truncates toward zero, remainder follows the dividend's sign.
// Dividing by zero returns quotient 0 and the raw dividend as remainder.
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   start      in   1      request, accepted only while idle
//   is_signed  in   1      two's-complement mode (if SIGNED_EN)
//   Divsrca    in   WIDTH  dividend
//   Divsrcb    in   WIDTH  divisor
//   busy       out  1      operation in progress
//   done       out  1      one-cycle completion pulse
//   DivHI      out  WIDTH  remainder
//   DivLO      out  WIDTH  quotient
//   by_zero    out  1      last completed operation divided by zero
// -----------------------------------------------------------------------------
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] Divsrca,
  input  logic [WIDTH-1:0] Divsrcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DivHI,
  output logic [WIDTH-1:0] DivLO,
  output logic             by_zero
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             sign_r;
  logic             zero_pend;
  logic             fix_phase;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvs),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  // Magnitudes of the latched operands. signed_q is already forced low when
  // the signed mode is disabled, so no extra gating is needed here.
  always_comb begin
    a_abs  = (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_abs  = (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
    b_zero = (b_q == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // FIX spends two cycles: first the sign correction is applied in place,
  // then the corrected values are copied to the result registers with done.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_PREP;
      S_PREP:  next_state = b_zero ? S_FIX : S_ITER;
      S_ITER:  if (count == LAST) next_state = S_FIX;
      S_FIX:   if (fix_phase) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      by_zero   <= 1'b0;
      DivHI     <= '0;
      DivLO     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero_pend <= 1'b0;
      fix_phase <= 1'b0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q      <= Divsrca;
            b_q      <= Divsrcb;
            signed_q <= SIGNED_EN & is_signed;
            busy     <= 1'b1;
          end
        end
        S_PREP: begin
          zero_pend <= b_zero;
          fix_phase <= 1'b0;
          if (!b_zero) begin
            rem    <= '0;
            quo    <= a_abs;
            dvs    <= b_abs;
            sign_q <= signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            sign_r <= signed_q & a_q[WIDTH-1];
            count  <= '0;
          end
        end
        S_ITER: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 1'b1;
        end
        S_FIX: begin
          if (!fix_phase) begin
            fix_phase <= 1'b1;
            if (zero_pend) begin
              quo <= '0;
              rem <= a_q;
            end else begin
              if (sign_q) quo <= -quo;
              if (sign_r) rem <= -rem;
            end
          end else begin
            fix_phase <= 1'b0;
            DivHI     <= rem;
            DivLO     <= quo;
            by_zero   <= zero_pend;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
